l2_tlb_lookup_ctrl: RTL and testbench

Front-end controller for the L2 TLB. It takes L1 miss requests from the ITLB and DTLB and arbitrates between them. It issues one lookup at a time to the L2 TLB, returns hits directly to the requester and forwards misses to the page-table walker. It sits between the L1 TLB miss paths and the L2 TLB/PTW, and keeps saturating hit/miss performance counters.

---
 rtl/l2_tlb_lookup_ctrl.sv | 139 +++++++++++++
 tb/tb_l2_tlb_lookup_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_tlb_lookup_ctrl.sv
// L2 TLB front-end: round-robin ITLB/DTLB miss arbiter, one lookup in flight,
// hits returned to the requester, misses forwarded to the PTW, saturating stats.
//
// Ports: clk_i/rst_i (sync, active-high), flush_i aborts the in-flight request;
// {itlb,dtlb}_req_{valid_i,ready_o,i} request side; l2_tlb_{access_o,req_o,hit_i,
// resp_i,flushing_i} L2 TLB side; resp_{valid_o,src_o,o} hit response;
// ptw_req_{valid_o,ready_i,o}/ptw_src_o miss side; hit_cnt_o/miss_cnt_o counters.

package l2_tlb_pkg;
  typedef struct packed {
    logic [26:0] vpn;
    logic [15:0] asid;
  } l2_tlb_req_t;

  typedef struct packed {
    logic [43:0] ppn;
    logic [7:0]  perm;
  } l2_tlb_resp_t;
endpackage

module l2_tlb_lookup_ctrl
  import l2_tlb_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 itlb_req_valid_i,
  output logic                 itlb_req_ready_o,
  input  l2_tlb_req_t          itlb_req_i,
  input  logic                 dtlb_req_valid_i,
  output logic                 dtlb_req_ready_o,
  input  l2_tlb_req_t          dtlb_req_i,
  output logic                 l2_tlb_access_o,
  output l2_tlb_req_t          l2_tlb_req_o,
  input  logic                 l2_tlb_hit_i,
  input  l2_tlb_resp_t         l2_tlb_resp_i,
  input  logic                 l2_tlb_flushing_i,
  output logic                 resp_valid_o,
  output logic                 resp_src_o,
  output l2_tlb_resp_t         resp_o,
  output logic                 ptw_req_valid_o,
  input  logic                 ptw_req_ready_i,
  output l2_tlb_req_t          ptw_req_o,
  output logic                 ptw_src_o,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT,
    RESP,
    MISS
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t       state;
  l2_tlb_req_t  req_q;
  l2_tlb_resp_t resp_q;
  logic         src_q;
  logic         last_q;
  logic [CNT_WIDTH-1:0] hit_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt;

  logic can_grant;
  logic pick_d;
  logic grant;
  logic sat_hit;
  logic sat_miss;

  // DTLB wins when it is alone, or on a tie when ITLB had the last grant.
  always_comb begin
    can_grant = (state == IDLE) && !flush_i && !l2_tlb_flushing_i;
    pick_d    = dtlb_req_valid_i && (!itlb_req_valid_i || !last_q);
    grant     = can_grant && (itlb_req_valid_i || dtlb_req_valid_i);
  end

  assign itlb_req_ready_o = grant && !pick_d;
  assign dtlb_req_ready_o = grant && pick_d;

  assign sat_hit  = (hit_cnt == '1);
  assign sat_miss = (miss_cnt == '1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      req_q    <= '0;
      resp_q   <= '0;
      src_q    <= 1'b0;
      last_q   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            req_q  <= pick_d ? dtlb_req_i : itlb_req_i;
            src_q  <= pick_d;
            last_q <= pick_d;
            state  <= LOOKUP;
          end
        end
        LOOKUP: state <= WAIT;
        WAIT: begin
          // A hit reported while the L2 TLB flushes is not trusted.
          if (l2_tlb_hit_i && !l2_tlb_flushing_i) begin
            resp_q <= l2_tlb_resp_i;
            if (!sat_hit) hit_cnt <= hit_cnt + CNT_ONE;
            state <= RESP;
          end else begin
            if (!sat_miss) miss_cnt <= miss_cnt + CNT_ONE;
            state <= MISS;
          end
        end
        RESP: state <= IDLE;
        MISS: if (ptw_req_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign l2_tlb_access_o = (state == LOOKUP) && !flush_i;
  assign l2_tlb_req_o    = req_q;
  assign resp_valid_o    = (state == RESP) && !flush_i;
  assign resp_src_o      = src_q;
  assign resp_o          = resp_q;
  assign ptw_req_valid_o = (state == MISS) && !flush_i;
  assign ptw_req_o       = req_q;
  assign ptw_src_o       = src_q;
  assign hit_cnt_o       = hit_cnt;
  assign miss_cnt_o      = miss_cnt;

endmodule

// File: tb/tb_l2_tlb_lookup_ctrl.sv
// Directed bench for l2_tlb_lookup_ctrl: table of IDLE grant vectors plus
// hand sequences for hit, miss, round-robin, flush, interlock and saturation.

module tb_l2_tlb_lookup_ctrl;
  import l2_tlb_pkg::*;

  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst, flush, iv, dv, hit, fls, pready;
  logic ir, dr, acc, rvalid, rsrc, pvalid, psrc;
  l2_tlb_req_t ireq, dreq, l2req, preq;
  l2_tlb_resp_t l2resp, resp;
  logic [CW-1:0] hcnt, mcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_tlb_lookup_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .itlb_req_valid_i(iv), .itlb_req_ready_o(ir), .itlb_req_i(ireq),
    .dtlb_req_valid_i(dv), .dtlb_req_ready_o(dr), .dtlb_req_i(dreq),
    .l2_tlb_access_o(acc), .l2_tlb_req_o(l2req),
    .l2_tlb_hit_i(hit), .l2_tlb_resp_i(l2resp),
    .l2_tlb_flushing_i(fls),
    .resp_valid_o(rvalid), .resp_src_o(rsrc), .resp_o(resp),
    .ptw_req_valid_o(pvalid), .ptw_req_ready_i(pready),
    .ptw_req_o(preq), .ptw_src_o(psrc),
    .hit_cnt_o(hcnt), .miss_cnt_o(mcnt)
  );

  typedef struct {
    logic iv, dv, fl, fls;
    logic ir, dr, acc;
  } vec_t;

  vec_t vecs[7];

  localparam l2_tlb_req_t PI = '{vpn: 27'h123_4567, asid: 16'hA1A1};
  localparam l2_tlb_req_t PD = '{vpn: 27'h7AB_CDEF, asid: 16'h5D5D};
  localparam l2_tlb_resp_t R1 = '{ppn: 44'hDEA_DBEE_F012, perm: 8'hC3};
  localparam l2_tlb_resp_t R2 = '{ppn: 44'h123_4567_89A, perm: 8'h5A};

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; iv = 1'b0; dv = 1'b0;
    hit = 1'b0; fls = 1'b0; pready = 1'b0;
    ireq = PI; dreq = PD; l2resp = '0;
    step();
    rst = 1'b0;
    #1;
  endtask

  // Requests from one side and ends in the WAIT cycle with hit/flushing driven.
  task automatic issue(input logic d, input logic h, input logic f,
                       input l2_tlb_resp_t r);
    if (d) dv = 1'b1;
    else iv = 1'b1;
    #1;
    chk("grant_ready", d ? dr : ir, 1'b1);
    chk("other_ready", d ? ir : dr, 1'b0);
    step();
    iv = 1'b0; dv = 1'b0;
    #1;
    chk("lookup_access", acc, 1'b1);
    chk("lookup_req", l2req, d ? PD : PI);
    step();
    chk("wait_no_access", acc, 1'b0);
    hit = h; fls = f; l2resp = r;
    #1;
  endtask

  initial begin
    int ng;
    logic [3:0] gseq;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[2] = '{0, 1, 0, 0, 0, 1, 1};
    vecs[3] = '{1, 1, 0, 0, 0, 1, 1};
    vecs[4] = '{1, 1, 1, 0, 0, 0, 0};
    vecs[5] = '{1, 0, 0, 1, 0, 0, 0};
    vecs[6] = '{0, 1, 1, 1, 0, 0, 0};

    do_reset();
    chk("rst_ready", {ir, dr}, 2'b00);
    chk("rst_valids", {acc, rvalid, pvalid}, 3'b000);
    chk("rst_src", {rsrc, psrc}, 2'b00);
    chk("rst_cnt", {hcnt, mcnt}, 4'h0);
    chk("rst_req", l2req, 0);
    chk("rst_preq", preq, 0);
    chk("rst_resp", resp, 0);

    foreach (vecs[i]) begin
      do_reset();
      iv = vecs[i].iv; dv = vecs[i].dv;
      flush = vecs[i].fl; fls = vecs[i].fls;
      #1;
      chk($sformatf("vec%0d_ir", i), ir, vecs[i].ir);
      chk($sformatf("vec%0d_dr", i), dr, vecs[i].dr);
      step();
      iv = 1'b0; dv = 1'b0; flush = 1'b0; fls = 1'b0;
      #1;
      chk($sformatf("vec%0d_acc", i), acc, vecs[i].acc);
      if (vecs[i].acc)
        chk($sformatf("vec%0d_req", i), l2req, vecs[i].dr ? PD : PI);
    end

    // Single DTLB hit: response in the cycle after WAIT.
    do_reset();
    issue(1'b1, 1'b1, 1'b0, R1);
    step();
    hit = 1'b0;
    #1;
    chk("hit_rvalid", rvalid, 1'b1);
    chk("hit_rsrc", rsrc, 1'b1);
    chk("hit_resp", resp, R1);
    chk("hit_cnt", hcnt, 2'd1);
    chk("hit_no_ptw", pvalid, 1'b0);
    step();
    chk("hit_pulse_end", rvalid, 1'b0);

    // ITLB miss with three cycles of PTW backpressure.
    issue(1'b0, 1'b0, 1'b0, R2);
    step();
    for (int c = 0; c < 4; c++) begin
      pready = (c == 3);
      #1;
      chk($sformatf("miss_pvalid%0d", c), pvalid, 1'b1);
      chk($sformatf("miss_preq%0d", c), preq, PI);
      chk($sformatf("miss_psrc%0d", c), psrc, 1'b0);
      step();
    end
    pready = 1'b0;
    #1;
    chk("miss_done", pvalid, 1'b0);
    chk("miss_cnt", mcnt, 2'd1);
    chk("miss_no_resp", rvalid, 1'b0);

    // Round-robin with both sides held; every lookup hits.
    do_reset();
    iv = 1'b1; dv = 1'b1; hit = 1'b1; l2resp = R2;
    ng = 0; gseq = '0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if (ir || dr) begin
        gseq[ng] = dr;
        ng++;
      end
      step();
    end
    iv = 1'b0; dv = 1'b0;
    chk("rr_grants", ng, 4);
    chk("rr_order", gseq, 4'b0101);
    for (int c = 0; c < 4; c++) step();
    hit = 1'b0;
    chk("sat_hit4", hcnt, 2'd3);
    chk("sat_miss0", mcnt, 2'd0);
    issue(1'b1, 1'b1, 1'b0, R1);
    step();
    hit = 1'b0;
    #1;
    chk("sat_rvalid", rvalid, 1'b1);
    chk("sat_hit5", hcnt, 2'd3);

    // Flush in WAIT drops the request entirely.
    do_reset();
    issue(1'b0, 1'b1, 1'b0, R1);
    flush = 1'b1;
    #1;
    chk("fw_gate", {rvalid, pvalid, acc}, 3'b000);
    step();
    flush = 1'b0; hit = 1'b0; iv = 1'b1;
    #1;
    chk("fw_no_out", {rvalid, pvalid}, 2'b00);
    chk("fw_idle", ir, 1'b1);
    iv = 1'b0;
    step();
    chk("fw_cnt", {hcnt, mcnt}, 4'h0);

    // Flush in MISS beats a simultaneous PTW ready.
    issue(1'b1, 1'b0, 1'b0, R1);
    step();
    chk("fm_pvalid", pvalid, 1'b1);
    flush = 1'b1; pready = 1'b1;
    #1;
    chk("fm_gate", pvalid, 1'b0);
    step();
    flush = 1'b0; pready = 1'b0; dv = 1'b1;
    #1;
    chk("fm_no_ptw", pvalid, 1'b0);
    chk("fm_idle", dr, 1'b1);
    chk("fm_miss_cnt", mcnt, 2'd1);
    dv = 1'b0;

    // Hit while the L2 TLB flushes is treated as a miss.
    do_reset();
    issue(1'b1, 1'b1, 1'b1, R1);
    step();
    hit = 1'b0; fls = 1'b0;
    #1;
    chk("fh_pvalid", pvalid, 1'b1);
    chk("fh_psrc", psrc, 1'b1);
    chk("fh_rvalid", rvalid, 1'b0);
    chk("fh_cnt", {hcnt, mcnt}, {2'd0, 2'd1});

    // Reset in MISS overrides a pending handshake.
    rst = 1'b1; pready = 1'b1;
    step();
    rst = 1'b0; pready = 1'b0;
    #1;
    chk("rm_pvalid", pvalid, 1'b0);
    chk("rm_cnt", {hcnt, mcnt}, 4'h0);
    chk("rm_preq", preq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
